multi_lane_transmitter: RTL

- Parametrised successor to the single-lane SDR/DDR test transmitter.
- Generates LANES independent WIDTH-bit test words internally and serialises each lane MSB-first onto its own data line. All lanes share one forwarded clock, bit-strobe and frame marker.
- Presents each word in parallel with a strobe, so the ISERDES checker can compare it against the deserialised result.
- Sits in front of the IOB/ISERDES under test in the sdr_ddr minitests.

---
 rtl/multi_lane_transmitter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/multi_lane_transmitter.sv
// Multi-lane SDR/DDR test transmitter: per-lane test words serialised MSB-first on a shared
// forwarded clock. Define MULTI_LANE_TRANSMITTER_PRBS_EN to source words from per-lane PRBS7.
module multi_lane_transmitter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1,
  parameter string       MODE  = "SDR"
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  output logic                   BUSY,
  output logic                   O_STB,
  output logic [LANES*WIDTH-1:0] O_DAT,
  output logic                   S_CLK,
  output logic                   S_CE,
  output logic                   S_FRM,
  output logic [LANES-1:0]       S_DAT
);
  localparam bit          IsDdr = (MODE == "DDR");
  localparam int unsigned BitW  = $clog2(WIDTH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             ph_q, ph_d, ph_inc;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [WIDTH-1:0]       shift_q [LANES];
  logic [WIDTH-1:0]       shift_d [LANES];
  logic [WIDTH-1:0]       new_word [LANES];
  logic                   busy_q, busy_d, stb_q, stb_d, sclk_q, sclk_d;
  logic                   ce_q, ce_d, frm_q, frm_d;
  logic [LANES*WIDTH-1:0] odat_q, odat_d;
  logic [LANES-1:0]       sdat_q, sdat_d;
  logic                   bit_edge, last_bit, load;

`ifdef MULTI_LANE_TRANSMITTER_PRBS_EN
  logic [6:0] lfsr_q [LANES];
  logic [6:0] lfsr_d [LANES];
  logic [6:0] lfsr_next [LANES];

  // x^7+x^6+1 Fibonacci: each new feedback bit is also the transmitted bit.
  function automatic logic [WIDTH+6:0] prbs_word(input logic [6:0] seed);
    logic [6:0]       s;
    logic [WIDTH-1:0] w;
    s = seed;
    w = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w = {w[WIDTH-2:0], s[6] ^ s[5]};
      s = {s[5:0], s[6] ^ s[5]};
    end
    return {w, s};
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      {new_word[l], lfsr_next[l]} = prbs_word(lfsr_q[l]);
    end
  end
`else
  logic [WIDTH-1:0] base_q, base_d;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      new_word[l] = base_q + WIDTH'(l);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    odat_d  = odat_q;
    stb_d   = 1'b0;
    ce_d    = 1'b0;
    load    = 1'b0;
`ifdef MULTI_LANE_TRANSMITTER_PRBS_EN
    lfsr_d  = lfsr_q;
`else
    base_d  = base_q;
`endif
    ph_inc   = ph_q + 2'd1;
    // SDR bits start on entry to ph 2; DDR bits on entry to ph 1 and ph 3.
    bit_edge = IsDdr ? ph_inc[0] : (ph_inc == 2'd2);
    last_bit = (bit_q == BitW'(WIDTH - 1));

    case (state_q)
      StIdle: begin
        if (EN) begin
          load    = 1'b1;
          state_d = StRun;
          ph_d    = IsDdr ? 2'd3 : 2'd2;
        end
      end
      StRun: begin
        ph_d = ph_inc;
        if (bit_edge) begin
          if (!last_bit) begin
            bit_d = bit_q + BitW'(1);
            ce_d  = 1'b1;
            for (int l = 0; l < LANES; l++) shift_d[l] = shift_q[l] << 1;
          end else if (EN) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            ph_d    = 2'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      bit_d = '0;
      ce_d  = 1'b1;
      stb_d = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        shift_d[l]                = new_word[l];
        odat_d[l*WIDTH +: WIDTH]  = new_word[l];
      end
`ifdef MULTI_LANE_TRANSMITTER_PRBS_EN
      lfsr_d = lfsr_next;
`else
      base_d = base_q + WIDTH'(LANES);
`endif
    end

    busy_d = (state_d == StRun);
    frm_d  = busy_d && (bit_d == '0);
    sclk_d = busy_d && !ph_d[1];
    for (int l = 0; l < LANES; l++) sdat_d[l] = busy_d & shift_d[l][WIDTH-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      ph_q    <= '0;
      bit_q   <= '0;
      for (int l = 0; l < LANES; l++) shift_q[l] <= '0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      odat_q  <= '0;
      sclk_q  <= 1'b0;
      ce_q    <= 1'b0;
      frm_q   <= 1'b0;
      sdat_q  <= '0;
`ifdef MULTI_LANE_TRANSMITTER_PRBS_EN
      for (int l = 0; l < LANES; l++) lfsr_q[l] <= 7'(l + 1);
`else
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      odat_q  <= odat_d;
      sclk_q  <= sclk_d;
      ce_q    <= ce_d;
      frm_q   <= frm_d;
      sdat_q  <= sdat_d;
`ifdef MULTI_LANE_TRANSMITTER_PRBS_EN
      lfsr_q  <= lfsr_d;
`else
      base_q  <= base_d;
`endif
    end
  end

  assign BUSY  = busy_q;
  assign O_STB = stb_q;
  assign O_DAT = odat_q;
  assign S_CLK = sclk_q;
  assign S_CE  = ce_q;
  assign S_FRM = frm_q;
  assign S_DAT = sdat_q;

endmodule
